// File: rtl/pstack_pkg.sv
// Shared Forth-core constants: parameter-stack op encoding and default word width.
// The decoder imports the same op constants to drive the stack.
package forth_pkg;
  localparam logic [1:0] PS_NONE    = 2'b00;
  localparam logic [1:0] PS_PUSH    = 2'b01;
  localparam logic [1:0] PS_POP     = 2'b10;
  localparam logic [1:0] PS_REPLACE = 2'b11;
  localparam int         WIDTH      = 16;
endpackage

// File: rtl/pstack_if.sv
// Decoder <-> parameter stack interface.
// Protocol: there is no valid/ready handshake. The decoder presents exactly one op
// per cycle (PS_NONE when idle), and the stack accepts it on that rising edge.
// Every status output is a registered value, except pstack_top, which is an
// asynchronous read of the RAM gated by the registered empty flag.
interface pstack_if #(
  parameter int width = 16,
  parameter int depth = 16
);
  localparam int pw = $clog2(depth);

  logic [1:0]       op;
  logic [width-1:0] push_data;
  logic             err_clr;
  logic [width-1:0] pstack_top;
  logic [pw:0]      count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;

  modport master (
    output op, push_data, err_clr,
    input  pstack_top, count, empty, full, ovf, unf
  );

  modport slave (
    input  op, push_data, err_clr,
    output pstack_top, count, empty, full, ovf, unf
  );
endinterface

// File: rtl/pstack_ram.sv
// Stack storage: depth x width, one synchronous write port and one asynchronous
// read port, so that it maps onto distributed RAM. Contents are not reset.
module pstack_ram #(
  parameter int width = 16,
  parameter int depth = 16,
  parameter int pw    = $clog2(depth)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [pw-1:0]    waddr_i,
  input  logic [width-1:0] wdata_i,
  input  logic [pw-1:0]    raddr_i,
  output logic [width-1:0] rdata_o
);
  logic [width-1:0] mem [depth];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/pstack.sv
// Parameter (data) stack for the Forth core. It holds every entry below TOS and
// presents NOS combinationally on pstack_top.
// Optional feature macro: PSTACK_ERR_EN (sticky ovf/unf flags with err_clr).
module pstack
  import forth_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int depth = 16
) (
  input logic     clk,
  input logic     reset,
  pstack_if.slave bus
);
  localparam int            pw        = $clog2(depth);
  localparam logic [pw-1:0] SP_ONE    = pw'(1);
  localparam logic [pw:0]   CNT_ONE   = (pw+1)'(1);
  localparam logic [pw:0]   CNT_DEPTH = (pw+1)'(depth);

  logic [pw-1:0]    sp_q, sp_d;
  logic [pw:0]      count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             we;
  logic [pw-1:0]    waddr;
  logic [width-1:0] rdata;
  logic             ovf_set, unf_set;

  // Op decode. A full PUSH wraps sp and overwrites the oldest entry; REPLACE on an
  // empty stack falls back to a PUSH.
  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    we      = 1'b0;
    waddr   = sp_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (bus.op)
      PS_PUSH: begin
        we      = 1'b1;
        sp_d    = sp_q + SP_ONE;
        count_d = full_q ? count_q : count_q + CNT_ONE;
        ovf_set = full_q;
      end
      PS_POP: begin
        if (empty_q) begin
          unf_set = 1'b1;
        end else begin
          sp_d    = sp_q - SP_ONE;
          count_d = count_q - CNT_ONE;
        end
      end
      PS_REPLACE: begin
        we = 1'b1;
        if (empty_q) begin
          sp_d    = sp_q + SP_ONE;
          count_d = CNT_ONE;
          unf_set = 1'b1;
        end else begin
          waddr = sp_q - SP_ONE;
        end
      end
      default: ;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_DEPTH);
  end

  // Pointer, occupancy and the registered empty/full flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q    <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  pstack_ram #(.width(width), .depth(depth), .pw(pw)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.push_data),
    .raddr_i (sp_q - SP_ONE),
    .rdata_o (rdata)
  );

  assign bus.pstack_top = empty_q ? '0 : rdata;
  assign bus.count      = count_q;
  assign bus.empty      = empty_q;
  assign bus.full       = full_q;

`ifdef PSTACK_ERR_EN
  logic ovf_q, unf_q;

  // Sticky misuse flags; a clear in the same cycle as a set wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.err_clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
`else
  logic unused_flags;
  assign unused_flags = bus.err_clr ^ ovf_set ^ unf_set;
  assign bus.ovf      = 1'b0;
  assign bus.unf      = 1'b0;
`endif
endmodule
